apb_slave_mem: RTL and testbench

Wait-state-capable APB slave with an internal byte-wide register memory. It is the downstream consumer of the APB master bridge. Two instances sit on the bus: one on PSEL1 (PADDR[8]=0) and one on PSEL2 (PADDR[8]=1). Each instance decodes PADDR[7:0], inserts a programmable number of wait states, and returns PREADY, PRDATA and PSLVERR to the bridge.

---
 rtl/apb_slave_mem.sv | 139 +++++++++++++
 tb/tb_apb_slave_mem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB slave with a byte-wide register memory and a fixed number of wait states.
// Address, direction and write data are captured in the setup phase and used for the whole access.
module apb_slave_mem #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic [7:0] PADDR,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic       PREADY,
    output logic [7:0] PRDATA,
    output logic       PSLVERR
);

    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_cnt_next;
    logic [7:0]       addr_q;
    logic             write_q;
    logic [7:0]       wdata_q;
    logic [7:0]       mem [MEM_DEPTH];
    logic             latch_req;
    logic             complete_next;
    logic             commit;
    logic             addr_err;
    logic [IDX_W-1:0] idx;

    // The compare is one bit wider so that MEM_DEPTH = 256 still works.
    assign addr_err = ({1'b0, addr_q} >= DEPTH_LIM);
    assign idx      = addr_q[IDX_W-1:0];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // complete_next marks the edge that opens the completing cycle, so PREADY
    // can stay a plain register; PREADY=1 in ACCESS means this is that cycle.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        latch_req     = 1'b0;
        complete_next = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch_req     = 1'b1;
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = SETUP;
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                complete_next = (wait_cnt == 4'd0);
            end
            ACCESS: begin
                if (PREADY) begin
                    commit        = write_q && !addr_err;
                    wait_cnt_next = 4'd0;
                    if (PSEL && !PENABLE) begin
                        latch_req     = 1'b1;
                        wait_cnt_next = WAIT_LOAD;
                        state_next    = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!PSEL) begin
                    wait_cnt_next = 4'd0;
                    state_next    = IDLE;
                end else if (wait_cnt != 4'd0) begin
                    wait_cnt_next = wait_cnt - 4'd1;
                    complete_next = (wait_cnt == 4'd1);
                end else begin
                    complete_next = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PRDATA  <= 8'h00;
            PSLVERR <= 1'b0;
            addr_q  <= 8'h00;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            PREADY  <= complete_next;
            PSLVERR <= complete_next && addr_err;
            if (complete_next && !write_q) begin
                PRDATA <= addr_err ? 8'h00 : mem[idx];
            end
            if (latch_req) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
        end
    end

    // The commit uses the previous transfer's latched data even when the same
    // edge latches a back-to-back successor.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (commit) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with 2 wait states, one with 0,
// sharing the bus except for their select lines.
module tb_apb_slave_mem;

    logic       PCLK;
    logic       PRESET;
    logic       sel_ws0;
    logic       sel_ws2;
    logic       penable;
    logic [7:0] paddr;
    logic       pwrite;
    logic [7:0] pwdata;
    logic       rdy0;
    logic [7:0] rd0;
    logic       err0;
    logic       rdy2;
    logic [7:0] rd2;
    logic       err2;

    int checks   = 0;
    int failures = 0;

    apb_slave_mem #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(sel_ws0), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
        .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0)
    );

    apb_slave_mem #(.MEM_DEPTH(64), .WAIT_STATES(2)) u_ws2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(sel_ws2), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
        .PREADY(rdy2), .PRDATA(rd2), .PSLVERR(err2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic ready_of(input int ws);
        return (ws == 0) ? rdy0 : rdy2;
    endfunction

    function automatic logic err_of(input int ws);
        return (ws == 0) ? err0 : err2;
    endfunction

    function automatic logic [7:0] rdata_of(input int ws);
        return (ws == 0) ? rd0 : rd2;
    endfunction

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Drives the bus setup phase; on return the slave is in SETUP and PENABLE is high.
    task automatic start_xfer(input int ws, input logic wr, input logic [7:0] a, input logic [7:0] d, input string tag);
        if (ws == 0) sel_ws0 = 1'b1;
        else         sel_ws2 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        step();
        check_output({tag, "_setup_rdy"}, 8'(ready_of(ws)), 8'h00);
        penable = 1'b1;
    endtask

    // Steps through A1..A(ws+1); returns inside the completing cycle.
    task automatic finish_xfer(input int ws, input logic wr, input logic exp_err, input logic [7:0] exp_rd, input string tag);
        for (int i = 1; i <= ws + 1; i++) begin
            step();
            if (i <= ws) begin
                check_output({tag, "_wait_rdy"}, 8'(ready_of(ws)), 8'h00);
                check_output({tag, "_wait_err"}, 8'(err_of(ws)), 8'h00);
            end else begin
                check_output({tag, "_done_rdy"}, 8'(ready_of(ws)), 8'h01);
                check_output({tag, "_done_err"}, 8'(err_of(ws)), 8'(exp_err));
                if (!wr) check_output({tag, "_rdata"}, rdata_of(ws), exp_rd);
            end
        end
    endtask

    task automatic go_idle(input int ws, input string tag);
        sel_ws0 = 1'b0;
        sel_ws2 = 1'b0;
        penable = 1'b0;
        step();
        check_output({tag, "_idle_rdy"}, 8'(ready_of(ws)), 8'h00);
        check_output({tag, "_idle_err"}, 8'(err_of(ws)), 8'h00);
    endtask

    task automatic apply_xfer(input int ws, input logic wr, input logic [7:0] a, input logic [7:0] d,
                              input logic exp_err, input logic [7:0] exp_rd, input string tag);
        start_xfer(ws, wr, a, d, tag);
        finish_xfer(ws, wr, exp_err, exp_rd, tag);
        go_idle(ws, tag);
    endtask

    initial begin
        PRESET  = 1'b1;
        sel_ws0 = 1'b0;
        sel_ws2 = 1'b0;
        penable = 1'b0;
        paddr   = 8'h00;
        pwrite  = 1'b0;
        pwdata  = 8'h00;
        #1;
        check_output("rst_rdy0", 8'(rdy0), 8'h00);
        check_output("rst_err0", 8'(err0), 8'h00);
        check_output("rst_rd0",  rd0,      8'h00);
        check_output("rst_rdy2", 8'(rdy2), 8'h00);
        check_output("rst_err2", 8'(err2), 8'h00);
        check_output("rst_rd2",  rd2,      8'h00);
        step();
        step();
        PRESET = 1'b0;
        step();

        // Write then read with two wait states.
        apply_xfer(2, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, "wr10");
        apply_xfer(2, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C, "rd10");

        // Reset asserted in A2 of a write; PRDATA was 3C beforehand.
        start_xfer(2, 1'b1, 8'h05, 8'hA5, "rstmid");
        step();
        check_output("rstmid_a1_rdy", 8'(rdy2), 8'h00);
        step();
        check_output("rstmid_a2_rdy", 8'(rdy2), 8'h00);
        PRESET = 1'b1;
        #1;
        check_output("rstmid_rdy", 8'(rdy2), 8'h00);
        check_output("rstmid_rd",  rd2,      8'h00);
        check_output("rstmid_err", 8'(err2), 8'h00);
        sel_ws2 = 1'b0;
        penable = 1'b0;
        step();
        PRESET = 1'b0;
        step();
        apply_xfer(2, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, "rd05_after_rst");
        apply_xfer(2, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, "rd10_after_rst");

        // Zero wait states, back-to-back with no idle cycles.
        start_xfer(0, 1'b1, 8'h00, 8'h11, "b2b_wr00");
        finish_xfer(0, 1'b1, 1'b0, 8'h00, "b2b_wr00");
        start_xfer(0, 1'b1, 8'h01, 8'h22, "b2b_wr01");
        finish_xfer(0, 1'b1, 1'b0, 8'h00, "b2b_wr01");
        start_xfer(0, 1'b0, 8'h00, 8'h00, "b2b_rd00");
        finish_xfer(0, 1'b0, 1'b0, 8'h11, "b2b_rd00");
        start_xfer(0, 1'b0, 8'h01, 8'h00, "b2b_rd01");
        finish_xfer(0, 1'b0, 1'b0, 8'h22, "b2b_rd01");
        go_idle(0, "b2b_end");
        check_output("b2b_rdata_hold", rd0, 8'h22);

        // Out-of-range address 0x40 must not alias onto location 0.
        apply_xfer(2, 1'b1, 8'h00, 8'h99, 1'b0, 8'h00, "wr00");
        apply_xfer(2, 1'b1, 8'h40, 8'hFF, 1'b1, 8'h00, "wr40_oor");
        apply_xfer(2, 1'b0, 8'h40, 8'h00, 1'b1, 8'h00, "rd40_oor");
        apply_xfer(2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h99, "rd00_after_oor");

        // Abort in A1 leaves the prior contents of 0x08.
        apply_xfer(2, 1'b1, 8'h08, 8'h44, 1'b0, 8'h00, "wr08");
        start_xfer(2, 1'b1, 8'h08, 8'h77, "abort");
        step();
        check_output("abort_a1_rdy", 8'(rdy2), 8'h00);
        sel_ws2 = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("abort_after_rdy", 8'(rdy2), 8'h00);
        end
        apply_xfer(2, 1'b0, 8'h08, 8'h00, 1'b0, 8'h44, "rd08_after_abort");

        // PENABLE high without a setup phase is ignored.
        sel_ws0 = 1'b1;
        penable = 1'b1;
        paddr   = 8'h01;
        pwrite  = 1'b1;
        pwdata  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("noset_rdy", 8'(rdy0), 8'h00);
        end
        sel_ws0 = 1'b0;
        penable = 1'b0;
        step();
        apply_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h22, "rd01_after_noset");

        // Bus changes during ACCESS are ignored; latched values are used.
        start_xfer(2, 1'b1, 8'h02, 8'h5A, "latch");
        step();
        check_output("latch_a1_rdy", 8'(rdy2), 8'h00);
        pwdata = 8'h00;
        paddr  = 8'h03;
        step();
        check_output("latch_a2_rdy", 8'(rdy2), 8'h00);
        step();
        check_output("latch_a3_rdy", 8'(rdy2), 8'h01);
        check_output("latch_a3_err", 8'(err2), 8'h00);
        go_idle(2, "latch");
        apply_xfer(2, 1'b0, 8'h02, 8'h00, 1'b0, 8'h5A, "rd02_latched");
        apply_xfer(2, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, "rd03_untouched");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
